whack_scorer: RTL and testbench
===============================

# whack_scorer

Player-side end of the mole display path. It receives each new mole index together with its single-cycle "new number" strobe, and watches the four active-low pushbuttons during a bounded response window. It classifies every mole as a hit or a miss and keeps saturating score and miss counters for the HEX digit display logic.

## Interface
- `WINDOW`, default 50_000_000: response window in clock cycles, ≥2; default is 1 s at 50 MHz.
- `HOLES`, default 4: number of valid mole positions/keys, 1–4; mole indices 0..HOLES-1.
- `clock`  in  1  system clock (CLOCK_50 at top level).
- `clear_b`  in  1  reset; one clock; reset is asynchronous and active-low.
- `new_mole`  in  1  single-cycle strobe; `mole_in` is valid in the same cycle.
- `mole_in`  in  4  mole index shown on the HEX digit.
- `key_n`  in  4  raw pushbuttons, active-low, asynchronous to `clock`; only bits below HOLES are used.
- `mole_active`  out  1  high while a mole is armed.
- `hit`  out  1  one-cycle pulse: mole whacked.
- `miss`  out  1  one-cycle pulse: mole missed (timeout, wrong key, mash or replacement).
- `score`  out  8  hit counter, saturating.
- `miss_count`  out  8  miss counter, saturating.

## Operation
- Key path:
  - Per key, a 2-flop synchronizer (`s1`, `s2`) followed by a `prev` register.
  - `press[i] = ~s2[i] & prev[i]` (falling edge of the synchronized level); one event per press.
  - A held key produces no repeat events.
- States:
  - IDLE: no mole.
  - ARMED: mole up, window counter running.
  - Transition from ARMED to IDLE registers the `hit`/`miss` pulse.
- IDLE:
  - `new_mole` with `mole_in < HOLES`: latch the index, load `win_cnt = WINDOW-1`, go to ARMED.
  - `new_mole` with `mole_in >= HOLES`: ignored; stay in IDLE.
  - Presses in IDLE are ignored (see Configuration).
- ARMED, priority highest first in a single cycle:
  1. Any press event whose set is exactly the latched key: `hit`, `score+1`, go to IDLE.
  2. Any other non-empty press set (wrong key, or correct key plus any other key = mash): `miss`, `miss_count+1`, go to IDLE.
  3. `new_mole` (any `mole_in`): old mole counts as a miss (`miss`, `miss_count+1`).
     - Valid new index: re-arm with the new index and reload `win_cnt`; stay in ARMED.
     - Invalid new index: go to IDLE.
  4. `win_cnt == 0`: timeout; `miss`, `miss_count+1`, go to IDLE.
  5. Otherwise `win_cnt - 1`.
- Press events have priority over a simultaneous `new_mole`. In that case the press result is recorded, the strobe is dropped and the block goes to IDLE.
- Counters:
  - 8-bit unsigned; `score` holds at 255 and `miss_count` holds at 255.
  - `win_cnt` width is `$clog2(WINDOW)`.
- `mole_active = (state == ARMED)`, registered.

## Timing
- Reset (async, `clear_b` low): `score = 0`, `miss_count = 0`, `hit = 0`, `miss = 0`, `mole_active = 0`, state IDLE, synchronizers and `prev` at 1 (released).
- Reset mid-ARMED aborts the mole with no pulse.
- Arm latency: `new_mole` sampled at edge A; `mole_active` is high after edge A.
- Key latency: `key_n` low before edge E1. The press is decided at E1+2 (E3), so `hit`/`miss` and counter updates are visible after E3.
- Timeout: armed at edge A with no press; `miss` is asserted after edge A+WINDOW, lasting one cycle.
- `hit` and `miss` are never high in the same cycle, and each is exactly one cycle wide.
- Back-to-back: a new mole may arm the cycle after a result; `new_mole` in the result cycle (state is then IDLE) is accepted.

## Configuration
- `WHACK_PENALTY_EN` defined:
  - A press event in IDLE is a false whack: `score` decrements by 1 (holds at 0), `miss` pulses and `miss_count` increments, with the same key-path latency.
  - Multiple simultaneous presses in IDLE count once.
- Not defined: presses in IDLE have no effect on any output.

## Test plan
- WINDOW=8, HOLES=4: reset, `new_mole` with `mole_in=2`, press `key_n[2]` 3 cycles later → one `hit` pulse, `score=1`, `miss_count=0`, `mole_active=0`.
- `new_mole` with `mole_in=1`, no press → `miss` exactly 8 cycles after arm, `miss_count=1`, `score` unchanged.
- `mole_in=0`, press keys 0 and 3 together → `miss`, `miss_count+1`. Then `mole_in=0`, press key 3 alone → `miss`.
- ARMED on 3, second `new_mole` with `mole_in=1` before timeout → `miss`, window restarts. Key 1 then gives `hit`; `mole_in=7` in IDLE is ignored.
- Preload `score` to 255 via 255 hits, then one more hit → `score` stays 255 and `hit` still pulses. Assert `clear_b` low while ARMED → all outputs 0 immediately, no pulse.
- Key 2 held low across two moles → only the first press event counts. With `WHACK_PENALTY_EN`, press in IDLE with `score=2` → `score=1`, `miss` pulse.

Source files
------------

// File: rtl/whack_scorer.sv
// Player-side mole scorer: synchronizes the four active-low keys and classifies each armed mole as a hit or a miss.
// Optional macro WHACK_PENALTY_EN: a press while no mole is armed costs one point and counts as a miss.
module whack_scorer #(
  parameter int WINDOW = 50_000_000,
  parameter int HOLES  = 4
) (
  input  logic       clock,
  input  logic       clear_b,
  input  logic       new_mole,
  input  logic [3:0] mole_in,
  input  logic [3:0] key_n,
  output logic       mole_active,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score,
  output logic [7:0] miss_count
);

  localparam int CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [3:0] HMASK = 4'((1 << HOLES) - 1);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t        state_q;
  logic [3:0]    s1_q, s2_q, prev_q;
  logic [1:0]    mole_q;
  logic [CW-1:0] win_cnt_q;
  logic          hit_q, miss_q;
  logic [7:0]    score_q, miss_cnt_q;
  logic [3:0]    press_d;
  logic [3:0]    target_d;
  logic          valid_in_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'd1;
  endfunction

  // Keys are asynchronous: two flops for metastability, a third to find the falling edge.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      s1_q   <= 4'hF;
      s2_q   <= 4'hF;
      prev_q <= 4'hF;
    end else begin
      s1_q   <= key_n;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign press_d    = ~s2_q & prev_q & HMASK;
  assign target_d   = 4'b0001 << mole_q;
  assign valid_in_d = (mole_in < 4'(HOLES));

  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      state_q    <= IDLE;
      mole_q     <= '0;
      win_cnt_q  <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      score_q    <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef WHACK_PENALTY_EN
          if (press_d != 4'b0000) begin
            score_q    <= sat_dec(score_q);
            miss_q     <= 1'b1;
            miss_cnt_q <= sat_inc(miss_cnt_q);
          end
`endif
          if (new_mole && valid_in_d) begin
            mole_q    <= mole_in[1:0];
            win_cnt_q <= CW'(WINDOW - 1);
            state_q   <= ARMED;
          end
        end
        ARMED: begin
          // Press results outrank a simultaneous new_mole, which is then dropped.
          if (press_d == target_d) begin
            hit_q   <= 1'b1;
            score_q <= sat_inc(score_q);
            state_q <= IDLE;
          end else if (press_d != 4'b0000) begin
            miss_q     <= 1'b1;
            miss_cnt_q <= sat_inc(miss_cnt_q);
            state_q    <= IDLE;
          end else if (new_mole) begin
            miss_q     <= 1'b1;
            miss_cnt_q <= sat_inc(miss_cnt_q);
            if (valid_in_d) begin
              mole_q    <= mole_in[1:0];
              win_cnt_q <= CW'(WINDOW - 1);
            end else begin
              state_q <= IDLE;
            end
          end else if (win_cnt_q == '0) begin
            miss_q     <= 1'b1;
            miss_cnt_q <= sat_inc(miss_cnt_q);
            state_q    <= IDLE;
          end else begin
            win_cnt_q <= win_cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mole_active = (state_q == ARMED);
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign score       = score_q;
  assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_whack_scorer.sv
// Scoreboard bench for whack_scorer with WINDOW=8, HOLES=4; expected pulses are queued by stimulus and popped by a monitor.
module tb_whack_scorer;

  localparam int WIN = 8;

  logic       clk = 1'b0;
  logic       clear_b = 1'b0;
  logic       new_mole = 1'b0;
  logic [3:0] mole_in = 4'd0;
  logic [3:0] key_n = 4'hF;
  logic       mole_active, hit, miss;
  logic [7:0] score, miss_count;

  typedef struct {
    logic       is_hit;
    logic [7:0] sc;
    logic [7:0] mc;
    int         at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   sc_m = 0;
  int   mc_m = 0;
  int   arm_cyc = 0;

  whack_scorer #(.WINDOW(WIN), .HOLES(4)) dut (
    .clock(clk), .clear_b(clear_b), .new_mole(new_mole), .mole_in(mole_in),
    .key_n(key_n), .mole_active(mole_active), .hit(hit), .miss(miss),
    .score(score), .miss_count(miss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // kind: 0 hit, 1 miss, 2 penalty (score down, miss up)
  task automatic expect_ev(input int kind, input int at);
    exp_t e;
    if (kind == 0) sc_m = (sc_m == 255) ? 255 : sc_m + 1;
    else mc_m = (mc_m == 255) ? 255 : mc_m + 1;
    if (kind == 2) sc_m = (sc_m == 0) ? 0 : sc_m - 1;
    e.is_hit = (kind == 0);
    e.sc = 8'(sc_m);
    e.mc = 8'(mc_m);
    e.at = at;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (clear_b && (hit || miss)) begin
      exp_t e;
      chk("hit_miss_exclusive", int'(hit && miss), 0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind_hit", int'(hit), int'(e.is_hit));
        chk("pulse_score", int'(score), int'(e.sc));
        chk("pulse_miss_count", int'(miss_count), int'(e.mc));
        if (e.at >= 0) chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [3:0] idx);
    new_mole = 1'b1;
    mole_in  = idx;
    step(1);
    new_mole = 1'b0;
    arm_cyc  = cyc;
  endtask

  // Short press: two cycles low, then released long enough for the sync chain to settle.
  task automatic press(input logic [3:0] mask, input int kind);
    key_n = ~mask;
    if (kind >= 0) expect_ev(kind, cyc + 3);
    step(2);
    key_n = 4'hF;
    step(4);
  endtask

  initial begin
    step(3);
    chk("rst_score", int'(score), 0);
    chk("rst_miss_count", int'(miss_count), 0);
    chk("rst_active", int'(mole_active), 0);
    chk("rst_pulses", int'(hit | miss), 0);
    clear_b = 1'b1;
    step(2);

    arm(4'd2);
    chk("arm_latency", int'(mole_active), 1);
    step(3);
    press(4'b0100, 0);
    chk("after_hit_idle", int'(mole_active), 0);
    chk("after_hit_score", int'(score), 1);

    arm(4'd1);
    expect_ev(1, arm_cyc + WIN);
    step(WIN + 2);
    chk("timeout_idle", int'(mole_active), 0);

    arm(4'd0);
    step(1);
    press(4'b1001, 1);
    arm(4'd0);
    press(4'b1000, 1);

    arm(4'd3);
    step(2);
    arm(4'd1);
    expect_ev(1, arm_cyc);
    chk("rearm_active", int'(mole_active), 1);
    press(4'b0010, 0);
    arm(4'd7);
    chk("invalid_ignored", int'(mole_active), 0);
    step(3);

    for (int i = 0; i < 254; i++) begin
      arm(4'd1);
      press(4'b0010, 0);
    end
    chk("score_saturated", int'(score), 255);
    chk("miss_count_kept", int'(miss_count), 4);

    arm(4'd2);
    step(1);
    clear_b = 1'b0;
    #1;
    chk("async_clr_score", int'(score), 0);
    chk("async_clr_miss_count", int'(miss_count), 0);
    chk("async_clr_active", int'(mole_active), 0);
    chk("async_clr_pulses", int'(hit | miss), 0);
    sc_m = 0;
    mc_m = 0;
    step(2);
    clear_b = 1'b1;
    step(10);

    arm(4'd2);
    key_n = 4'b1011;
    expect_ev(0, cyc + 3);
    step(5);
    arm(4'd2);
    expect_ev(1, arm_cyc + WIN);
    step(WIN + 2);
    key_n = 4'hF;
    step(5);
    arm(4'd0);
    press(4'b0001, 0);
    chk("score_before_idle_press", int'(score), 2);

`ifdef WHACK_PENALTY_EN
    press(4'b0100, 2);
    step(2);
    chk("penalty_score", int'(score), 1);
    chk("penalty_miss_count", int'(miss_count), 2);
`else
    press(4'b0100, -1);
    step(2);
    chk("idle_press_score", int'(score), 2);
    chk("idle_press_miss_count", int'(miss_count), 1);
`endif

    step(5);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
